exception_entry: RTL and testbench

//  Exception-entry stage of the multi-cycle reference CPU: arbitrates pending exception causes,

---
 rtl/exception_entry_pkg.sv | 48 ++++
 rtl/exc_priority_enc.sv | 39 +++
 rtl/exception_entry.sv | 206 ++++++++++++++++++++
 tb/tb_exception_entry.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_entry_pkg.sv
// Shared definitions for the exception-entry stage: cause encodings, CP0 field layouts, FSM states.
package exception_entry_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam int          EXC_NUM_CAUSES     = 8;

  localparam int EXC_BIT_INT        = 0;
  localparam int EXC_BIT_ADEL_FETCH = 1;
  localparam int EXC_BIT_RI         = 2;
  localparam int EXC_BIT_OV         = 3;
  localparam int EXC_BIT_SYS        = 4;
  localparam int EXC_BIT_BP         = 5;
  localparam int EXC_BIT_ADEL_DATA  = 6;
  localparam int EXC_BIT_ADES       = 7;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [13:0] rsvd_hi;
    logic [7:0] ip;
    logic       rsvd_mid;
    exc_code_t  exc_code;
    logic [1:0] rsvd_lo;
  } cause_t;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_REDIRECT
  } exc_state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority cause encoder: lowest set exc_vec bit wins; flags which source supplies BadVAddr.
module exc_priority_enc
  import exception_entry_pkg::*;
(
  input  logic [EXC_NUM_CAUSES-1:0] exc_vec,
  output logic                      valid,
  output exc_code_t                 code,
  output logic                      is_fetch,
  output logic                      is_data
);

  always_comb begin
    valid    = |exc_vec;
    code     = EXC_INT;
    is_fetch = 1'b0;
    is_data  = 1'b0;
    if (exc_vec[EXC_BIT_INT]) begin
      code = EXC_INT;
    end else if (exc_vec[EXC_BIT_ADEL_FETCH]) begin
      code     = EXC_ADEL;
      is_fetch = 1'b1;
    end else if (exc_vec[EXC_BIT_RI]) begin
      code = EXC_RI;
    end else if (exc_vec[EXC_BIT_OV]) begin
      code = EXC_OV;
    end else if (exc_vec[EXC_BIT_SYS]) begin
      code = EXC_SYS;
    end else if (exc_vec[EXC_BIT_BP]) begin
      code = EXC_BP;
    end else if (exc_vec[EXC_BIT_ADEL_DATA]) begin
      code    = EXC_ADEL;
      is_data = 1'b1;
    end else if (exc_vec[EXC_BIT_ADES]) begin
      code    = EXC_ADES;
      is_data = 1'b1;
    end
  end

endmodule

// File: rtl/exception_entry.sv
// Exception-entry stage: accepts a request, saves EPC/Cause/BadVAddr, sets EXL, pulses a redirect.
// Optional count/compare timer interrupt is enabled by defining EXC_TIMER_IRQ_EN.
module exception_entry
  import exception_entry_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          NUM_CAUSES = EXC_NUM_CAUSES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NUM_CAUSES-1:0] exc_vec,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_delayed,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret_valid,
  input  logic [5:0]            ext_int,
  input  logic                  status_ie,
  input  logic [7:0]            status_im,
  output logic                  int_pending,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [31:0]           epc,
  output logic [31:0]           cause,
  output logic [31:0]           badvaddr,
  output logic                  status_exl
`ifdef EXC_TIMER_IRQ_EN
  ,
  input  logic                  compare_we,
  input  logic [31:0]           compare_wdata,
  output logic [31:0]           count
`endif
);

  exc_state_t  state_q, state_d;
  exc_code_t   pend_code_q, pend_code_d, code_q, code_d;
  logic [31:0] pend_pc_q, pend_pc_d, pend_vaddr_q, pend_vaddr_d;
  logic        pend_delayed_q, pend_delayed_d, pend_fetch_q, pend_fetch_d, pend_data_q, pend_data_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d, exl_q, exl_d;
  logic [5:0]  ext_q, ext_d;
  logic [5:0]  ip_hw;
  logic        ti;

  logic        enc_valid, enc_fetch, enc_data;
  exc_code_t   enc_code;
  logic        accept;
  cause_t      cause_s;
  status_t     status_s;

  exc_priority_enc u_prio (
    .exc_vec  (exc_vec),
    .valid    (enc_valid),
    .code     (enc_code),
    .is_fetch (enc_fetch),
    .is_data  (enc_data)
  );

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d        = state_q;
    pend_code_d    = pend_code_q;
    pend_pc_d      = pend_pc_q;
    pend_vaddr_d   = pend_vaddr_q;
    pend_delayed_d = pend_delayed_q;
    pend_fetch_d   = pend_fetch_q;
    pend_data_d    = pend_data_q;
    code_d         = code_q;
    epc_d          = epc_q;
    badvaddr_d     = badvaddr_q;
    bd_d           = bd_q;
    exl_d          = exl_q;
    ext_d          = ext_int;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d        = S_SAVE;
          pend_code_d    = enc_code;
          pend_pc_d      = exc_pc;
          pend_vaddr_d   = exc_badvaddr;
          pend_delayed_d = exc_delayed;
          pend_fetch_d   = enc_fetch;
          pend_data_d    = enc_data;
        end else if (eret_valid) begin
          exl_d = 1'b0;
        end
      end
      S_SAVE: begin
        state_d = S_REDIRECT;
        code_d  = pend_code_q;
        // A nested exception keeps the original EPC/BD so the outer handler can still return.
        if (!exl_q) begin
          epc_d = pend_delayed_q ? (pend_pc_q - 32'd4) : pend_pc_q;
          bd_d  = pend_delayed_q;
        end
        exl_d = 1'b1;
        if (pend_fetch_q) begin
          badvaddr_d = pend_pc_q;
        end else if (pend_data_q) begin
          badvaddr_d = pend_vaddr_q;
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pend_code_q    <= EXC_INT;
      pend_pc_q      <= '0;
      pend_vaddr_q   <= '0;
      pend_delayed_q <= 1'b0;
      pend_fetch_q   <= 1'b0;
      pend_data_q    <= 1'b0;
      code_q         <= EXC_INT;
      epc_q          <= '0;
      badvaddr_q     <= '0;
      bd_q           <= 1'b0;
      exl_q          <= 1'b0;
      ext_q          <= '0;
    end else begin
      state_q        <= state_d;
      pend_code_q    <= pend_code_d;
      pend_pc_q      <= pend_pc_d;
      pend_vaddr_q   <= pend_vaddr_d;
      pend_delayed_q <= pend_delayed_d;
      pend_fetch_q   <= pend_fetch_d;
      pend_data_q    <= pend_data_d;
      code_q         <= code_d;
      epc_q          <= epc_d;
      badvaddr_q     <= badvaddr_d;
      bd_q           <= bd_d;
      exl_q          <= exl_d;
      ext_q          <= ext_d;
    end
  end

`ifdef EXC_TIMER_IRQ_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tick_q, tick_d, ti_q, ti_d;

  // Count advances on every second cycle; TI latches on a match until Compare is rewritten.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q + {31'd0, tick_q};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (compare_we) begin
      compare_d = compare_wdata;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count = count_q;
  assign ti    = ti_q;
  assign ip_hw = {ti_q | ext_q[5], ext_q[4:0]};
`else
  assign ti    = 1'b0;
  assign ip_hw = ext_q;
`endif

  always_comb begin
    cause_s          = '0;
    cause_s.bd       = bd_q;
    cause_s.ti       = ti;
    cause_s.ip       = {ip_hw, 2'b00};
    cause_s.exc_code = code_q;
  end

  assign status_s       = '{im: status_im, exl: exl_q, ie: status_ie};
  assign int_pending    = (|(cause_s.ip & status_s.im)) & status_s.ie & ~status_s.exl;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = EXC_VECTOR;
  assign epc            = epc_q;
  assign cause          = cause_s;
  assign badvaddr       = badvaddr_q;
  assign status_exl     = exl_q;

  a_accept_has_cause: assert property (@(posedge clk) disable iff (reset) accept |-> enc_valid)
    else $error("exception_entry: request accepted with empty exc_vec");
  a_eret_only_idle: assert property (@(posedge clk) disable iff (reset)
    eret_valid |-> (state_q == S_IDLE) && !accept)
    else $error("exception_entry: eret_valid while busy or together with an accept");

endmodule

// File: tb/tb_exception_entry.sv
// Self-checking bench for exception_entry: cycle-level reference model plus directed literal checks.
module tb_exception_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  exc_vec = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_delayed = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret_valid = 1'b0;
  logic [5:0]  ext_int = '0;
  logic        status_ie = 1'b0;
  logic [7:0]  status_im = '0;
  logic        int_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] cause;
  logic [31:0] badvaddr;
  logic        status_exl;

  exception_entry dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .exc_vec        (exc_vec),
    .exc_pc         (exc_pc),
    .exc_delayed    (exc_delayed),
    .exc_badvaddr   (exc_badvaddr),
    .eret_valid     (eret_valid),
    .ext_int        (ext_int),
    .status_ie      (status_ie),
    .status_im      (status_im),
    .int_pending    (int_pending),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .cause          (cause),
    .badvaddr       (badvaddr),
    .status_exl     (status_exl)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic int lowestBit(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] codeOf(input int b);
    case (b)
      0: return 5'd0;
      1: return 5'd4;
      2: return 5'd10;
      3: return 5'd12;
      4: return 5'd8;
      5: return 5'd9;
      6: return 5'd4;
      default: return 5'd5;
    endcase
  endfunction

  // Reference model: an accepted request stamped at edge n saves at edge n+1,
  // redirect is visible for the cycle after that edge, and the block is idle again after edge n+2.
  int          edge_cnt   = 0;
  int          m_acc_edge = -10;
  bit          m_live     = 1'b0;
  logic [31:0] m_epc, m_badvaddr, m_pc, m_vaddr;
  logic        m_bd, m_exl, m_delayed;
  logic [4:0]  m_code, m_pcode;
  logic [5:0]  m_ip;
  int          m_kind;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (reset) begin
      m_live     <= 1'b1;
      m_acc_edge <= -10;
      m_epc      <= '0;
      m_badvaddr <= '0;
      m_bd       <= 1'b0;
      m_exl      <= 1'b0;
      m_code     <= '0;
      m_ip       <= '0;
    end else begin
      m_ip <= ext_int;
      if (edge_cnt - m_acc_edge >= 2) begin
        if (req_valid) begin
          m_acc_edge <= edge_cnt + 1;
          m_pcode    <= codeOf(lowestBit(exc_vec));
          m_pc       <= exc_pc;
          m_vaddr    <= exc_badvaddr;
          m_delayed  <= exc_delayed;
          m_kind     <= (lowestBit(exc_vec) == 1) ? 1 : ((lowestBit(exc_vec) >= 6) ? 2 : 0);
        end else if (eret_valid) begin
          m_exl <= 1'b0;
        end
      end
      if (edge_cnt == m_acc_edge) begin
        m_code <= m_pcode;
        if (!m_exl) begin
          m_epc <= m_delayed ? m_pc - 32'd4 : m_pc;
          m_bd  <= m_delayed;
        end
        m_exl <= 1'b1;
        if (m_kind == 1) m_badvaddr <= m_pc;
        else if (m_kind == 2) m_badvaddr <= m_vaddr;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("cyc_req_ready", {31'd0, req_ready}, {31'd0, (edge_cnt - m_acc_edge) >= 2});
      checkOutput("cyc_redirect_valid", {31'd0, redirect_valid}, {31'd0, edge_cnt == m_acc_edge + 1});
      checkOutput("cyc_redirect_pc", redirect_pc, 32'hBFC0_0380);
      checkOutput("cyc_epc", epc, m_epc);
      checkOutput("cyc_cause", cause, {m_bd, 1'b0, 14'd0, m_ip, 2'b00, 1'b0, m_code, 2'b00});
      checkOutput("cyc_badvaddr", badvaddr, m_badvaddr);
      checkOutput("cyc_status_exl", {31'd0, status_exl}, {31'd0, m_exl});
      checkOutput("cyc_int_pending", {31'd0, int_pending},
                  {31'd0, (|({m_ip, 2'b00} & status_im)) & status_ie & ~m_exl});
    end
  end

  // Presents one request in an idle cycle; returns just after the accept edge (block in save phase).
  task automatic applyStimulus(input logic [7:0] vec, input logic [31:0] pc, input logic dly,
                               input logic [31:0] bva);
    @(posedge clk); #2;
    req_valid    = 1'b1;
    exc_vec      = vec;
    exc_pc       = pc;
    exc_delayed  = dly;
    exc_badvaddr = bva;
    @(posedge clk); #2;
    req_valid = 1'b0;
    exc_vec   = '0;
  endtask

  task automatic doEret();
    @(posedge clk); #2;
    eret_valid = 1'b1;
    @(posedge clk); #2;
    eret_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_epc", epc, 32'd0);
    checkOutput("rst_cause", cause, 32'd0);
    checkOutput("rst_badvaddr", badvaddr, 32'd0);
    checkOutput("rst_exl", {31'd0, status_exl}, 32'd0);
    checkOutput("rst_int_pending", {31'd0, int_pending}, 32'd0);
    reset = 1'b0;

    // RI, no delay slot
    applyStimulus(8'h04, 32'h8000_0100, 1'b0, 32'd0);
    checkOutput("ri_no_early_redirect", {31'd0, redirect_valid}, 32'd0);
    @(posedge clk); #2;
    checkOutput("ri_redirect", {31'd0, redirect_valid}, 32'd1);
    checkOutput("ri_redirect_pc", redirect_pc, 32'hBFC0_0380);
    checkOutput("ri_epc", epc, 32'h8000_0100);
    checkOutput("ri_cause", cause, 32'h0000_0028);
    checkOutput("ri_exl", {31'd0, status_exl}, 32'd1);
    checkOutput("model_ri_epc", m_epc, 32'h8000_0100);
    doEret();
    checkOutput("ri_eret_exl", {31'd0, status_exl}, 32'd0);

    // Ov beats Sys, delay slot
    applyStimulus(8'h18, 32'h8000_0204, 1'b1, 32'd0);
    @(posedge clk); #2;
    checkOutput("ov_cause", cause, 32'h8000_0030);
    checkOutput("ov_epc", epc, 32'h8000_0200);
    checkOutput("model_ov_code", {27'd0, m_code}, 32'd12);
    doEret();

    // AdES data address
    applyStimulus(8'h80, 32'h8000_0500, 1'b0, 32'h1234_5679);
    @(posedge clk); #2;
    checkOutput("ades_cause", cause, 32'h0000_0014);
    checkOutput("ades_badvaddr", badvaddr, 32'h1234_5679);
    doEret();
    checkOutput("ades_eret_exl", {31'd0, status_exl}, 32'd0);

    // Nested: Bp then Sys while EXL set
    applyStimulus(8'h20, 32'h8000_0400, 1'b0, 32'd0);
    @(posedge clk); #2;
    checkOutput("bp_cause", cause, 32'h0000_0024);
    applyStimulus(8'h10, 32'h8000_0300, 1'b1, 32'd0);
    @(posedge clk); #2;
    checkOutput("nested_redirect", {31'd0, redirect_valid}, 32'd1);
    checkOutput("nested_epc", epc, 32'h8000_0400);
    checkOutput("nested_cause", cause, 32'h0000_0020);
    checkOutput("nested_exl", {31'd0, status_exl}, 32'd1);
    doEret();

    // Fetch AdEL at PC 0 in delay slot: EPC wraps, BadVAddr takes the PC
    applyStimulus(8'h06, 32'h0000_0000, 1'b1, 32'h0000_DEAD);
    @(posedge clk); #2;
    checkOutput("wrap_epc", epc, 32'hFFFF_FFFC);
    checkOutput("wrap_cause", cause, 32'h8000_0010);
    checkOutput("wrap_badvaddr", badvaddr, 32'h0000_0000);
    doEret();

    // Int wins over AdES; BadVAddr untouched
    applyStimulus(8'h81, 32'h8000_0600, 1'b0, 32'h0000_5555);
    @(posedge clk); #2;
    checkOutput("int_cause", cause, 32'h0000_0000);
    checkOutput("int_badvaddr", badvaddr, 32'h0000_0000);
    checkOutput("int_epc", epc, 32'h8000_0600);
    doEret();

    // External interrupt line through Cause.IP
    @(posedge clk); #2;
    ext_int   = 6'h01;
    status_im = 8'h04;
    status_ie = 1'b1;
    #1;
    checkOutput("irq_before_sample", {31'd0, int_pending}, 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    checkOutput("irq_pending", {31'd0, int_pending}, 32'd1);
    checkOutput("irq_cause_ip", cause, 32'h0000_0400);
    status_im = 8'h00;
    #1;
    checkOutput("irq_masked", {31'd0, int_pending}, 32'd0);
    ext_int   = 6'h00;
    status_ie = 1'b0;

    // Reset while saving
    applyStimulus(8'h04, 32'h8000_0700, 1'b0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("abort_redirect", {31'd0, redirect_valid}, 32'd0);
    checkOutput("abort_epc", epc, 32'd0);
    reset = 1'b0;
    @(posedge clk); #2;
    checkOutput("abort_no_late_redirect", {31'd0, redirect_valid}, 32'd0);

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
